// File: rtl/sfr_pkg.sv
// sfr_pkg: shared state encoding, word geometry and helpers for the SPI flash
// read-data packer. Optional checksum build: define SFR_PACK_CHKSUM_EN.
package sfr_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_WAIT_LAST,
        ST_DONE
    } sfr_state_e;

    // Mode encodings already used by spi_flash_read; kept here for benches.
    typedef enum logic [1:0] {
        MODE_SINGLE = 2'b00,
        MODE_DUAL   = 2'b01,
        MODE_QUAD   = 2'b10
    } sfr_mode_e;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  be;
        logic        last;
    } sfr_word_t;

    // Byte-enable of a closing word holding 'lane' bytes (0 -> empty word).
    function automatic logic [3:0] lane_mask(input logic [1:0] lane);
        case (lane)
            2'd0:    return 4'b0000;
            2'd1:    return 4'b0001;
            2'd2:    return 4'b0011;
            default: return 4'b0111;
        endcase
    endfunction

    // Closing word data: the first 'lane' buffered bytes, all other bytes zero.
    function automatic logic [31:0] close_data(input logic [23:0] bytes,
                                               input logic [1:0]  lane);
        logic [23:0] keep;
        case (lane)
            2'd0:    keep = 24'h000000;
            2'd1:    keep = 24'h0000FF;
            2'd2:    keep = 24'h00FFFF;
            default: keep = 24'hFFFFFF;
        endcase
        return {8'h00, bytes & keep};
    endfunction

endpackage

// File: rtl/sfr_out_reg.sv
// sfr_out_reg: single-entry valid/ready holding register for packed words.
// Abort empties the slot at once; the caller only loads when the slot is free.
module sfr_out_reg
    import sfr_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      load_i,
    input  sfr_word_t load_word_i,
    input  logic      abort_i,
    input  logic      ready_i,
    output logic      valid_o,
    output sfr_word_t word_o
);

    logic      valid_q;
    sfr_word_t word_q;

    // Abort wins, then a load (which may replace a departing word), then a plain accept empties the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            valid_q <= 1'b0;
            // NOTE: the payload is reset as well as valid, so data/byte_en/last all read 0 out of reset.
            word_q  <= '0;
        end else if (abort_i) begin
            valid_q <= 1'b0;
            word_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            word_q  <= load_word_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign word_o  = word_q;

endmodule

// File: rtl/spi_flash_rd_packer.sv
// spi_flash_rd_packer: drains the spi_flash_read byte FIFO, packs bytes
// little-endian into 32-bit words and closes each transfer with a tagged last
// word. Define SFR_PACK_CHKSUM_EN to add a running 16-bit byte sum on chksum.
module spi_flash_rd_packer
    import sfr_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int WORD_BYTES = sfr_pkg::WORD_BYTES
) (
    input  logic             system_clk,
    input  logic             system_reset_n,
    input  logic             start_flag,
    input  logic             read_finish,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [7:0]       fifo_rd_data,
    output logic [31:0]      word_data,
    output logic [3:0]       word_byte_en,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             word_last,
    output logic [CNT_W-1:0] byte_count,
    output logic             pack_done
`ifdef SFR_PACK_CHKSUM_EN
    ,
    output logic [15:0]      chksum
`endif
);

    if (WORD_BYTES != 4) begin : g_bad_word_bytes
        $error("spi_flash_rd_packer: WORD_BYTES must be 4");
    end

    sfr_state_e       state_q, state_d;
    logic             start_prev_q;
    logic [1:0]       lane_q, lane_d;
    logic             pend_q;
    logic             fin_q, fin_d;
    logic [23:0]      buf_q, buf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic      start_rise, out_free, byte_take;
    logic      load, abort;
    sfr_word_t load_word, out_word;

    assign start_rise = start_flag && !start_prev_q;
    assign out_free   = !word_valid || word_ready;
    // A byte returning in RUN while the transfer is still live gets packed.
    assign byte_take  = (state_q == ST_RUN) && start_flag && pend_q;

    // Never pop the word-completing byte unless the output slot frees this cycle.
    assign fifo_rd_en = (state_q == ST_RUN) && !fifo_empty && !pend_q &&
                        !(lane_q == 2'd3 && word_valid && !word_ready);

    // Next-state and packing decisions for the transfer FSM.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d   = state_q;
        lane_d    = lane_q;
        fin_d     = fin_q;
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        load      = 1'b0;
        load_word = '0;
        abort     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    lane_d  = 2'd0;
                    fin_d   = 1'b0;
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!start_flag) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    fin_d = fin_q | read_finish;
                    if (byte_take) begin
                        cnt_d  = cnt_q + CNT_W'(1);
                        lane_d = lane_q + 2'd1;
                        case (lane_q)
                            2'd0: buf_d[7:0]   = fifo_rd_data;
                            2'd1: buf_d[15:8]  = fifo_rd_data;
                            2'd2: buf_d[23:16] = fifo_rd_data;
                            default: begin
                                load           = 1'b1;
                                load_word.data = {fifo_rd_data, buf_q};
                                load_word.be   = 4'hF;
                                load_word.last = 1'b0;
                            end
                        endcase
                    end
                    // The byte returning this cycle is already counted above.
                    if (fin_d && fifo_empty) state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!start_flag) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                end else if (out_free) begin
                    load           = 1'b1;
                    load_word.data = close_data(buf_q, lane_q);
                    load_word.be   = lane_mask(lane_q);
                    load_word.last = 1'b1;
                    state_d        = ST_WAIT_LAST;
                end
            end
            ST_WAIT_LAST: begin
                if (!start_flag) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                end else if (word_valid && word_ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!start_flag) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state, packing buffer, counters and the one-deep pop tracker.
    always_ff @(posedge system_clk or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state_q      <= ST_IDLE;
            start_prev_q <= 1'b0;
            lane_q       <= 2'd0;
            pend_q       <= 1'b0;
            fin_q        <= 1'b0;
            buf_q        <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_flag;
            lane_q       <= lane_d;
            pend_q       <= fifo_rd_en;
            fin_q        <= fin_d;
            buf_q        <= buf_d;
            cnt_q        <= cnt_d;
        end
    end

    sfr_out_reg u_out_reg (
        .clk         (system_clk),
        .rst_n       (system_reset_n),
        .load_i      (load),
        .load_word_i (load_word),
        .abort_i     (abort),
        .ready_i     (word_ready),
        .valid_o     (word_valid),
        .word_o      (out_word)
    );

    assign word_data    = out_word.data;
    assign word_byte_en = out_word.be;
    assign word_last    = out_word.last;
    assign byte_count   = cnt_q;
    assign pack_done    = (state_q == ST_DONE);

`ifdef SFR_PACK_CHKSUM_EN
    logic [15:0] chk_q;

    // Running sum of packed bytes: cleared on start, untouched outside RUN.
    always_ff @(posedge system_clk or negedge system_reset_n) begin
        if (!system_reset_n) begin
            chk_q <= '0;
        end else if (state_q == ST_IDLE && start_rise) begin
            chk_q <= '0;
        end else if (byte_take) begin
            chk_q <= chk_q + {8'h00, fifo_rd_data};
        end
    end

    assign chksum = chk_q;
`endif

endmodule

// File: doc/spi_flash_rd_packer.md
Name: spi_flash_rd_packer

Overview:
- Downstream consumer of spi_flash_read. Drains its byte-wide read-data FIFO and packs bytes little-endian into 32-bit words.
- Presents the words on a valid/ready stream to the system side (DMA / host bridge).
- Tracks the byte count and closes the transfer with a tagged last word once spi_flash_read signals read_finish.

Parameters:
- CNT_W, 32, width of the byte counter; covers a full start_addr..end_addr span, including die-crossing reads.
- WORD_BYTES, 4, bytes per output word; fixed at 4 in this revision, and other values are a lint error.

Ports:
- system_clk  in  1  single clock for the block.
- system_reset_n  in  1  asynchronous, active-low reset.
- start_flag  in  1  same level signal that drives spi_flash_read. Rising edge starts a transfer; a low level aborts or finishes one.
- read_finish  in  1  from spi_flash_read; level, sampled only in RUN.
- fifo_empty  in  1  read FIFO empty flag.
- fifo_rd_en  out  1  FIFO pop; data is valid on fifo_rd_data one cycle after the pop.
- fifo_rd_data  in  8  FIFO read data.
- word_data  out  32  packed word; byte 0 is in [7:0].
- word_byte_en  out  4  valid-byte lanes of word_data.
- word_valid  out  1  output stream valid.
- word_ready  in  1  output stream ready.
- word_last  out  1  marks the final word of the transfer.
- byte_count  out  CNT_W  bytes accepted from the FIFO since start.
- pack_done  out  1  transfer closed; last word accepted.

Behaviour:
- Reset: all outputs are 0, state is IDLE, and all internal registers are cleared. Reset asserted mid-transfer discards everything immediately.
- States:
  - IDLE: on start_flag 0->1, clear byte_count, lane index, sticky finish and buffered word, then go to RUN.
  - RUN: pop and pack bytes. Latch read_finish into a sticky flag. Go to FLUSH once the sticky flag is set, fifo_empty=1, and no pop is outstanding.
  - FLUSH: load the closing word into the output register as soon as that register is free, then go to WAIT_LAST.
    - If lane!=0: partial word, byte_en = (1<<lane)-1, unused bytes 0.
    - If lane==0: empty word, byte_en=4'b0000, data 0.
    - word_last=1 in both cases.
  - WAIT_LAST: hold until word_valid&&word_ready, then go to DONE.
  - DONE: pack_done=1. Stay until start_flag=0, then go to IDLE.
- Pop rule: fifo_rd_en = RUN && !fifo_empty && !pend && !(lane==3 && word_valid && !word_ready).
  - pend is a 1-cycle flag set by a pop, so at most one byte is in flight.
  - Each returned byte is written into lane[1:0], the lane increments, and byte_count increments.
- Word completion: when byte lane 3 is written, the word moves to the output register with word_valid=1, byte_en=4'hF, word_last=0, and lane wraps to 0.
  - If word_ready and word_valid are both high in that same cycle, the new word replaces the departing one with no bubble.
- Stream rules: word_data, word_byte_en and word_last are stable while word_valid && !word_ready. word_valid drops only after a handshake, except on abort.
- Abort: start_flag=0 in RUN, FLUSH or WAIT_LAST goes to IDLE next cycle. The buffered word is discarded and word_valid drops. An in-flight FIFO byte is still consumed (pend cleared) but ignored.
- Simultaneous events: a byte returning in the same cycle that read_finish first rises is still packed. The FLUSH condition is evaluated after that byte is counted.
- Wrap-around: byte_count wraps modulo 2^CNT_W; there is no saturation.
- Overflow: never pops past the output register, so no data is lost under backpressure. The FIFO fills and spi_flash_read stalls on its full flag.

Optional Feature:
- Macro SFR_PACK_CHKSUM_EN.
- When defined: adds output port chksum [15:0], a running 16-bit sum (mod 2^16) of every packed byte. It is cleared on start and frozen in DONE.
- When undefined: no port and no logic.

Decomposition:
- Shared package sfr_pkg holds:
  - state encoding (IDLE, RUN, FLUSH, WAIT_LAST, DONE);
  - the WORD_BYTES constant;
  - the mode encodings already used by spi_flash_read (00 single, 01 dual, 10 quad) for benches.
- One natural sub-module: sfr_out_reg, a single-entry valid/ready holding register with the load/accept/abort ports.

Test Plan:
- Aligned 16 bytes: FIFO preloaded 00..0F, word_ready=1, read_finish after last byte -> 4 words 03020100, 07060504, 0B0A0908, 0F0E0D0C, all byte_en F; then an empty word byte_en=0 with last=1; byte_count=16; pack_done.
- Unaligned 17 bytes (0x1000..0x1010): bytes A0..B0 -> 4 full words plus a final word 000000B0 with byte_en=0001, last=1; byte_count=17.
- Backpressure: word_ready toggled 1-in-4 with 32 bytes in the FIFO -> no byte lost or duplicated, data stable while stalled, fifo_rd_en=0 while lane==3 and stalled.
- Abort: start_flag dropped after 6 bytes -> IDLE next cycle, word_valid=0, no last; a restart then yields byte_count starting from 0.
- Async reset asserted mid-word (lane=2) -> all outputs 0 immediately; a new start produces a correct first word.
- Die-crossing span 0x01FFFFF0..0x02000010 (33 bytes): 8 full words plus a last word with byte_en=0001; with SFR_PACK_CHKSUM_EN, chksum equals the bench-computed sum.
